bus_nxm: RTL and testbench

BUS_NXM -- requirements
Module: bus_nxm

---
 rtl/bus_nxm_if.sv | 38 +++
 rtl/bus_nxm.sv | 169 ++++++++++++++++
 tb/tb_bus_nxm.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bus_nxm_if.sv
// Shared bus bundle for the N-master / M-slave interconnect.
// master : the request side (drives requests, address, write data)
// slave  : the target side (sees select/address/write data, returns read data)
// fabric : the interconnect itself
interface bus_nxm_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 5,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS-1:0]        m_wr;
  logic [NUM_MASTERS*ADDR_W-1:0] m_address;
  logic [NUM_MASTERS*DATA_W-1:0] m_dout;
  logic [NUM_SLAVES*DATA_W-1:0]  s_dout;
  logic [NUM_MASTERS-1:0]        m_grant;
  logic [DATA_W-1:0]             m_din;
  logic [NUM_SLAVES-1:0]         s_sel;
  logic                          s_wr;
  logic [ADDR_W-1:0]             s_address;
  logic [DATA_W-1:0]             s_din;
  logic                          decode_err;

  modport master (
    output m_req, m_wr, m_address, m_dout,
    input  m_grant, m_din, decode_err
  );

  modport slave (
    input  s_sel, s_wr, s_address, s_din,
    output s_dout
  );

  modport fabric (
    input  m_req, m_wr, m_address, m_dout, s_dout,
    output m_grant, m_din, s_sel, s_wr, s_address, s_din, decode_err
  );
endinterface

// File: rtl/bus_nxm.sv
// Round-robin N-master / M-slave shared bus with optional hold limit,
// address-based slave decode and a one-cycle registered read return path.
module bus_nxm #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 5,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int SLAVE_SHIFT = 8,
  parameter int MAX_HOLD    = 0
) (
  input  logic      clk,
  input  logic      reset,
  bus_nxm_if.fabric bus
);

  localparam int LW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int LW1 = LW + 1;
  localparam int SW  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_MASTERS - 1);

  // Next master index in ring order.
  function automatic logic [LW-1:0] wrap_inc(input logic [LW-1:0] idx);
    logic [LW-1:0] res;
    if (idx == LW'(NUM_MASTERS - 1)) res = {LW{1'b0}};
    else                             res = idx + LW'(1);
    return res;
  endfunction

  // First requesting master at or after start, wrapping around the ring.
  function automatic logic [LW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [LW-1:0]          start);
    logic [LW-1:0]  win;
    logic [LW1-1:0] pos;
    win = start;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      pos = {1'b0, start} + LW1'(i);
      if (pos >= LW1'(NUM_MASTERS)) pos = pos - LW1'(NUM_MASTERS);
      else                          pos = pos;
      if (req[pos[LW-1:0]]) win = pos[LW-1:0];
      else                  win = win;
    end
    return win;
  endfunction

  // Index of the set bit of a one-hot vector (0 when empty).
  function automatic logic [LW-1:0] oh_enc(input logic [NUM_MASTERS-1:0] oh);
    logic [LW-1:0] idx;
    idx = {LW{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) idx = LW'(i);
      else       idx = idx;
    end
    return idx;
  endfunction

  logic [NUM_MASTERS-1:0] grant_r, grant_nxt_s;
  logic [LW-1:0]          last_r, last_nxt_s;
  logic [HW-1:0]          hold_r, hold_nxt_s;
  logic                   rd_valid_r;
  logic [SW-1:0]          rd_idx_r;

  logic [LW-1:0]     owner_s, start_s, pick_s;
  logic              any_grant_s, own_req_s, other_req_s, hold_done_s;
  logic [ADDR_W-1:0] s_address_s, slv_idx_s;
  logic [DATA_W-1:0] s_din_s, m_din_s;
  logic              s_wr_s, in_range_s;
  logic [NUM_SLAVES-1:0] s_sel_s;

  assign owner_s     = oh_enc(grant_r);
  assign any_grant_s = |grant_r;
  assign own_req_s   = |(bus.m_req & grant_r);
  assign other_req_s = |(bus.m_req & ~grant_r);
  assign hold_done_s = (MAX_HOLD > 0) && (hold_r == HW'(MAX_HOLD));
  // Search begins just past the owner, or past the last owner when idle.
  assign start_s     = any_grant_s ? wrap_inc(owner_s) : wrap_inc(last_r);
  assign pick_s      = rr_pick(bus.m_req, start_s);

  // Arbitration: keep, hand over, or go idle; track hold length.
  always_comb begin
    grant_nxt_s = grant_r;
    last_nxt_s  = last_r;
    hold_nxt_s  = hold_r;
    if (!any_grant_s || !own_req_s || (hold_done_s && other_req_s)) begin
      if (|bus.m_req) begin
        grant_nxt_s         = {NUM_MASTERS{1'b0}};
        grant_nxt_s[pick_s] = 1'b1;
        last_nxt_s          = pick_s;
      end else begin
        grant_nxt_s = {NUM_MASTERS{1'b0}};
      end
    end else begin
      grant_nxt_s = grant_r;
    end

    if (grant_nxt_s == {NUM_MASTERS{1'b0}}) begin
      hold_nxt_s = {HW{1'b0}};
    end else if (grant_nxt_s != grant_r) begin
      hold_nxt_s = HW'(1);
    end else if (hold_r < HW'(MAX_HOLD)) begin
      hold_nxt_s = hold_r + HW'(1);
    end else begin
      hold_nxt_s = hold_r;
    end
  end

  // Steer the granted master onto the slave side; zero when nobody owns the bus.
  always_comb begin
    s_address_s = {ADDR_W{1'b0}};
    s_din_s     = {DATA_W{1'b0}};
    s_wr_s      = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_r[i]) begin
        s_address_s = bus.m_address[i*ADDR_W +: ADDR_W];
        s_din_s     = bus.m_dout[i*DATA_W +: DATA_W];
        s_wr_s      = bus.m_wr[i];
      end else begin
        s_wr_s = s_wr_s;
      end
    end
  end

  assign slv_idx_s  = s_address_s >> SLAVE_SHIFT;
  assign in_range_s = slv_idx_s < ADDR_W'(NUM_SLAVES);

  // Decode the slave select from the granted address.
  always_comb begin
    s_sel_s = {NUM_SLAVES{1'b0}};
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (any_grant_s && in_range_s && (slv_idx_s == ADDR_W'(k))) s_sel_s[k] = 1'b1;
      else                                                         s_sel_s[k] = 1'b0;
    end
  end

  // Return data of the slave selected in the previous cycle.
  always_comb begin
    m_din_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (rd_valid_r && (rd_idx_r == SW'(k))) m_din_s = bus.s_dout[k*DATA_W +: DATA_W];
      else                                    m_din_s = m_din_s;
    end
  end

  // State registers: grant, round-robin pointer, hold counter, read select.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r    <= {NUM_MASTERS{1'b0}};
      last_r     <= LAST_RST;
      hold_r     <= {HW{1'b0}};
      rd_valid_r <= 1'b0;
      rd_idx_r   <= {SW{1'b0}};
    end else begin
      grant_r    <= grant_nxt_s;
      last_r     <= last_nxt_s;
      hold_r     <= hold_nxt_s;
      rd_valid_r <= any_grant_s && in_range_s;
      rd_idx_r   <= slv_idx_s[SW-1:0];
    end
  end

  assign bus.m_grant    = grant_r;
  assign bus.s_address  = s_address_s;
  assign bus.s_din      = s_din_s;
  assign bus.s_wr       = s_wr_s;
  assign bus.s_sel      = s_sel_s;
  assign bus.decode_err = any_grant_s && !in_range_s;
  assign bus.m_din      = m_din_s;

endmodule

// File: tb/tb_bus_nxm.sv
// Directed bench: dut_a uses default parameters, dut_b has three masters
// and a hold limit of four cycles.
module tb_bus_nxm;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bus_nxm_if #(.NUM_MASTERS(2), .NUM_SLAVES(5), .ADDR_W(16), .DATA_W(32)) ia ();
  bus_nxm_if #(.NUM_MASTERS(3), .NUM_SLAVES(5), .ADDR_W(16), .DATA_W(32)) ib ();

  bus_nxm #(.NUM_MASTERS(2), .NUM_SLAVES(5), .ADDR_W(16), .DATA_W(32),
            .SLAVE_SHIFT(8), .MAX_HOLD(0)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  bus_nxm #(.NUM_MASTERS(3), .NUM_SLAVES(5), .ADDR_W(16), .DATA_W(32),
            .SLAVE_SHIFT(8), .MAX_HOLD(4)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (ia.m_grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected %b", ia.m_grant, 2'b00); end
    checks++; if (ia.s_sel !== 5'b00000) begin errors++; $display("FAIL reset_sel: got %b expected %b", ia.s_sel, 5'b00000); end
    checks++; if (ia.s_address !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected %h", ia.s_address, 16'h0000); end
    checks++; if (ia.s_din !== 32'h0) begin errors++; $display("FAIL reset_din: got %h expected %h", ia.s_din, 32'h0); end
    checks++; if (ia.s_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected %b", ia.s_wr, 1'b0); end
    checks++; if (ia.m_din !== 32'h0) begin errors++; $display("FAIL reset_mdin: got %h expected %h", ia.m_din, 32'h0); end
    checks++; if (ia.decode_err !== 1'b0) begin errors++; $display("FAIL reset_derr: got %b expected %b", ia.decode_err, 1'b0); end
    checks++; if (ib.m_grant !== 3'b000) begin errors++; $display("FAIL reset_grant_b: got %b expected %b", ib.m_grant, 3'b000); end
  endtask

  task automatic test_round_robin();
    ia.m_req = 2'b11;
    #1;
    checks++; if (ia.m_grant !== 2'b00) begin errors++; $display("FAIL rr_registered: got %b expected %b", ia.m_grant, 2'b00); end
    tick();
    checks++; if (ia.m_grant !== 2'b01) begin errors++; $display("FAIL rr_first: got %b expected %b", ia.m_grant, 2'b01); end
    ia.m_req = 2'b10;
    tick();
    checks++; if (ia.m_grant !== 2'b10) begin errors++; $display("FAIL rr_handover: got %b expected %b", ia.m_grant, 2'b10); end
    ia.m_req = 2'b00;
    tick();
    checks++; if (ia.m_grant !== 2'b00) begin errors++; $display("FAIL rr_idle: got %b expected %b", ia.m_grant, 2'b00); end
    ia.m_req = 2'b11;
    tick();
    checks++; if (ia.m_grant !== 2'b01) begin errors++; $display("FAIL rr_after_m1: got %b expected %b", ia.m_grant, 2'b01); end
    ia.m_req = 2'b00;
    tick();
    ia.m_req = 2'b11;
    tick();
    checks++; if (ia.m_grant !== 2'b10) begin errors++; $display("FAIL rr_after_m0: got %b expected %b", ia.m_grant, 2'b10); end
    ia.m_req = 2'b00;
    tick();
  endtask

  task automatic test_write();
    ia.m_address = {16'h0100, 16'h0312};
    ia.m_dout    = {32'h11111111, 32'hDEADBEEF};
    ia.m_wr      = 2'b01;
    ia.m_req     = 2'b01;
    tick();
    checks++; if (ia.s_sel !== 5'b01000) begin errors++; $display("FAIL wr_sel: got %b expected %b", ia.s_sel, 5'b01000); end
    checks++; if (ia.s_address !== 16'h0312) begin errors++; $display("FAIL wr_addr: got %h expected %h", ia.s_address, 16'h0312); end
    checks++; if (ia.s_din !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_din: got %h expected %h", ia.s_din, 32'hDEADBEEF); end
    checks++; if (ia.s_wr !== 1'b1) begin errors++; $display("FAIL wr_strobe: got %b expected %b", ia.s_wr, 1'b1); end
    ia.m_req = 2'b10;
    tick();
    checks++; if (ia.s_address !== 16'h0100) begin errors++; $display("FAIL b2b_addr: got %h expected %h", ia.s_address, 16'h0100); end
    checks++; if (ia.s_sel !== 5'b00010) begin errors++; $display("FAIL b2b_sel: got %b expected %b", ia.s_sel, 5'b00010); end
    checks++; if (ia.s_din !== 32'h11111111) begin errors++; $display("FAIL b2b_din: got %h expected %h", ia.s_din, 32'h11111111); end
    checks++; if (ia.s_wr !== 1'b0) begin errors++; $display("FAIL b2b_wr: got %b expected %b", ia.s_wr, 1'b0); end
    ia.m_req = 2'b00;
    ia.m_wr  = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_read();
    ia.s_dout    = {32'hA0000004, 32'hA0000003, 32'hA0000002, 32'h12345678, 32'hA0000000};
    ia.m_address = {16'h0105, 16'h0000};
    ia.m_req     = 2'b10;
    tick();
    checks++; if (ia.s_sel !== 5'b00010) begin errors++; $display("FAIL rd_sel: got %b expected %b", ia.s_sel, 5'b00010); end
    checks++; if (ia.m_din !== 32'h0) begin errors++; $display("FAIL rd_first_cycle: got %h expected %h", ia.m_din, 32'h0); end
    tick();
    checks++; if (ia.m_din !== 32'h12345678) begin errors++; $display("FAIL rd_data: got %h expected %h", ia.m_din, 32'h12345678); end
    ia.m_req = 2'b00;
    tick();
    checks++; if (ia.m_din !== 32'h12345678) begin errors++; $display("FAIL rd_last: got %h expected %h", ia.m_din, 32'h12345678); end
    checks++; if (ia.s_sel !== 5'b00000) begin errors++; $display("FAIL rd_idle_sel: got %b expected %b", ia.s_sel, 5'b00000); end
    tick();
    checks++; if (ia.m_din !== 32'h0) begin errors++; $display("FAIL rd_released: got %h expected %h", ia.m_din, 32'h0); end
  endtask

  task automatic test_decode_err();
    ia.m_address = {16'h0105, 16'h0700};
    ia.m_req     = 2'b01;
    tick();
    checks++; if (ia.s_sel !== 5'b00000) begin errors++; $display("FAIL derr_sel: got %b expected %b", ia.s_sel, 5'b00000); end
    checks++; if (ia.decode_err !== 1'b1) begin errors++; $display("FAIL derr_flag: got %b expected %b", ia.decode_err, 1'b1); end
    ia.m_req = 2'b00;
    tick();
    checks++; if (ia.decode_err !== 1'b0) begin errors++; $display("FAIL derr_pulse: got %b expected %b", ia.decode_err, 1'b0); end
    checks++; if (ia.m_din !== 32'h0) begin errors++; $display("FAIL derr_mdin: got %h expected %h", ia.m_din, 32'h0); end
    tick();
  endtask

  task automatic test_max_hold();
    logic [2:0] exp_g;
    ib.m_req = 3'b111;
    tick();
    for (int i = 0; i < 13; i++) begin
      exp_g = 3'b001 << ((i / 4) % 3);
      checks++; if (ib.m_grant !== exp_g) begin errors++; $display("FAIL hold_rotate[%0d]: got %b expected %b", i, ib.m_grant, exp_g); end
      tick();
    end
    ib.m_req = 3'b000;
    tick();
    // A lone owner keeps the bus past the limit, then yields at once when challenged.
    ib.m_req = 3'b001;
    tick();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (ib.m_grant !== 3'b001) begin errors++; $display("FAIL hold_alone: got %b expected %b", ib.m_grant, 3'b001); end
    ib.m_req = 3'b011;
    tick();
    checks++; if (ib.m_grant !== 3'b010) begin errors++; $display("FAIL hold_saturated: got %b expected %b", ib.m_grant, 3'b010); end
    ib.m_req = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid();
    ia.m_req = 2'b10;
    tick();
    ia.m_req = 2'b11;
    tick();
    checks++; if (ia.m_grant !== 2'b10) begin errors++; $display("FAIL mid_owner: got %b expected %b", ia.m_grant, 2'b10); end
    reset = 1'b1;
    tick();
    checks++; if (ia.m_grant !== 2'b00) begin errors++; $display("FAIL mid_in_reset: got %b expected %b", ia.m_grant, 2'b00); end
    checks++; if (ia.s_address !== 16'h0000) begin errors++; $display("FAIL mid_addr: got %h expected %h", ia.s_address, 16'h0000); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (ia.m_grant !== 2'b00) begin errors++; $display("FAIL mid_release: got %b expected %b", ia.m_grant, 2'b00); end
    tick();
    checks++; if (ia.m_grant !== 2'b01) begin errors++; $display("FAIL mid_rearb: got %b expected %b", ia.m_grant, 2'b01); end
    ia.m_req = 2'b00;
    tick();
  endtask

  // Test sequence.
  initial begin
    clk          = 1'b0;
    reset        = 1'b1;
    checks       = 0;
    errors       = 0;
    ia.m_req     = 2'b00;
    ia.m_wr      = 2'b00;
    ia.m_address = 32'h0;
    ia.m_dout    = 64'h0;
    ia.s_dout    = 160'h0;
    ib.m_req     = 3'b000;
    ib.m_wr      = 3'b000;
    ib.m_address = 48'h0;
    ib.m_dout    = 96'h0;
    ib.s_dout    = 160'h0;
    test_reset();
    test_round_robin();
    test_write();
    test_read();
    test_decode_err();
    test_max_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
